memory_h_seq: RTL and testbench
===============================

# memory_h_seq

Address/handshake sequencer sitting directly in front of the hidden-state memories (`memory_h1` / `memory_h2`). It accepts the stream of new hidden values `h_t` from the LSTM layer over a valid/ready handshake, turns them into `wr`/`wr_addr` writes, and on request sweeps `rd_addr` across one timestep slot to feed `h_{t-1}` to the gate matrix stage. It also produces a valid/last strobe aligned with the memory's registered read port. One instance serves each hidden memory.

## Interface
Parameters:
- `WIDTH`, default 32: hidden value width.
- `NUM_LSTM`, default 53: units per layer; number of words per timestep slot.
- `TIMESTEP`, default 7: timesteps per sequence. Memory depth is `NUM_LSTM*(TIMESTEP+1)` and must be ≤ 4096.

Ports (clock and reset first):
- `clk` input 1: single clock; all logic rises on this edge.
- `rst` input 1: asynchronous, active-low reset. Memory instances in the top level receive `~rst`.
- `seq_clr` input 1: pulse; write pointer returns to timestep 0, unit 0.
- `h_valid` input 1: `h_data` valid.
- `h_data` input WIDTH (signed): new hidden value, unit order 0..NUM_LSTM-1.
- `h_ready` output 1: write side can accept.
- `rd_start` input 1: pulse; begin read sweep of slot `rd_t`.
- `rd_t` input 4: slot to read; slot `t` holds `h_{t-1}`, slot 0 holds the initial state.
- `wr` output 1: memory write enable.
- `wr_addr` output 12: memory write address.
- `wr_data` output WIDTH: equals `h_data`.
- `rd_addr` output 12: memory read address.
- `rd_valid` output 1: memory `o` is valid this cycle.
- `rd_last` output 1: with `rd_valid`, marks unit NUM_LSTM-1.
- `busy` output 1: read sweep in progress.
- `seq_done` output 1: one-cycle pulse after the last unit of timestep TIMESTEP-1 is written.
- `err` output 1: sticky error (see Configuration).

## Operation
- Write side: counters `wu` (unit) and `wt` (timestep).
  - `h_ready = (wt < TIMESTEP)`.
  - `wr = h_valid & h_ready` (combinational). `wr_addr = (wt+1)*NUM_LSTM + wu`.
  - On a handshake, `wu` increments. When `wu` wraps from NUM_LSTM-1 to 0, `wt` increments.
  - When `wt` reaches TIMESTEP: `h_ready` = 0, `seq_done` pulses next cycle, and the pointer holds until `seq_clr`.
- Read FSM:
  - IDLE: on `rd_start`, latch `base = rd_t*NUM_LSTM`, set `ru = 0`, go to RUN. `rd_start` while in RUN is ignored.
  - RUN: in each cycle with `wr == 0`, issue `rd_addr = base + ru` and increment `ru`. A cycle with `wr == 1` stalls issue, because the memory does not update `o` during writes. After issuing `ru = NUM_LSTM-1`, go to DRAIN.
  - DRAIN: one cycle, then IDLE.
- `rd_valid` and `rd_last` are registered copies of "issued this cycle" and "issued last unit".
- `busy` = (state != IDLE).
- `rd_addr` holds its last value when not issuing.
- Simultaneous `seq_clr` and handshake: `seq_clr` wins, the write is suppressed (`wr` = 0), and `h_ready` = 0 that cycle.
- Address arithmetic: 12-bit unsigned, computed from registered counters. No multiply on the critical path: `base` is accumulated as a running sum, or comes from a constant multiply of the latched `rd_t`.

## Timing
- Reset values: `wu = wt = ru = 0`, state IDLE, `rd_addr = wr_addr = 0`, `rd_valid = rd_last = busy = seq_done = err = 0`. `h_ready` = 1 as soon as reset is released.
- Reset asserted mid-sweep or mid-sequence aborts immediately. Memory contents are not touched by this block.
- Latency: `rd_start` sampled at edge N puts the FSM in RUN from N. The first `rd_addr` is driven in cycle N+1, and `rd_valid` rises in cycle N+2.
- Unstalled sweep: NUM_LSTM issue cycles, `rd_valid` high NUM_LSTM consecutive cycles, `busy` high NUM_LSTM+1 cycles.
- Each `wr`-high cycle during RUN inserts exactly one `rd_valid` bubble.
- Write throughput: one word per cycle; zero-latency `h_ready`.

## Configuration
- Macro `MEMORY_H_SEQ_BOUNDS_EN`.
- Defined:
  - `rd_start` with `rd_t > TIMESTEP` is rejected: FSM stays IDLE and `err` is set.
  - `h_valid` while `h_ready == 0` also sets `err`.
  - `err` clears only on reset or `seq_clr`.
- Undefined: no checks, `err` tied to 0, and out-of-range `rd_t` produces unchecked addresses.

## Structure
- Shared package `lstm_mem_pkg`: `ADDR_W = 12`, `T_W = 4`, the read FSM state enum, and the function `h_slot_addr(t, u, num_lstm)`. The package is shared with the cell-state sequencer.
- One sub-module, `unit_step_counter`: a two-level wrap counter with enable, clear, and terminal flags. It is instantiated for the write pointer and for the read unit counter.

## Test plan
Settings: NUM_LSTM=8, TIMESTEP=7.
1. Release reset and stream 8 values with `h_valid` held high -> `wr` high 8 cycles, `wr_addr` = 8..15, `h_ready` stays 1.
2. Stream 56 values -> the last write is at `wr_addr` 63, `seq_done` pulses once, `h_ready` = 0; `seq_clr` then restores `h_ready` = 1 and the next `wr_addr` = 8.
3. `rd_start` with `rd_t` = 3 and no writes -> `rd_addr` = 24..31, `rd_valid` high 8 cycles starting 2 cycles after the start edge, `rd_last` on the 8th.
4. `rd_t` = 0 sweep with 2 single-cycle writes injected mid-sweep -> exactly 2 bubbles in `rd_valid`, all 8 reads delivered in order (addresses 0..7).
5. `seq_clr` and `h_valid` in the same cycle -> `wr` = 0, pointer at 0. Reset asserted mid-sweep -> `busy`, `rd_valid`, `ru` all 0 immediately.
6. With `MEMORY_H_SEQ_BOUNDS_EN`: `rd_t` = 9 -> no sweep and `err` = 1. Without the macro: `err` stays 0.

Source files
------------

// File: rtl/lstm_mem_pkg.sv
// Shared definitions for the hidden/cell-state memory sequencers:
// address widths, read FSM states and the slot address helper.
package lstm_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int T_W    = 4;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_RUN   = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_e;

  // Flat address of unit u inside timestep slot t.
  function automatic logic [ADDR_W-1:0] h_slot_addr(
    input logic [T_W-1:0]    t,
    input logic [ADDR_W-1:0] u,
    input int                num_lstm
  );
    int a;
    a = int'(t) * num_lstm + int'(u);
    return a[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/memory_h_seq_if.sv
// Hidden-value stream and hidden-memory port bundle between the LSTM
// layer, the sequencer and the memory.
interface memory_h_seq_if #(
  parameter int WIDTH = 32
);

  logic                               h_valid;
  logic signed [WIDTH-1:0]            h_data;
  logic                               h_ready;
  logic                               wr;
  logic [lstm_mem_pkg::ADDR_W-1:0]    wr_addr;
  logic [WIDTH-1:0]                   wr_data;
  logic [lstm_mem_pkg::ADDR_W-1:0]    rd_addr;
  logic                               rd_valid;
  logic                               rd_last;

  modport master (
    output h_valid, h_data,
    input  h_ready, wr, wr_addr, wr_data, rd_addr, rd_valid, rd_last
  );

  modport slave (
    input  h_valid, h_data,
    output h_ready, wr, wr_addr, wr_data, rd_addr, rd_valid, rd_last
  );

endinterface

// File: rtl/memory_h_seq_unit_step_counter.sv
// Two-level unit/step counter: inner wraps at INNER-1 and carries into
// outer, which saturates at OUTER and then ignores enable until cleared.
module unit_step_counter #(
  parameter int INNER = 8,
  parameter int OUTER = 7,
  parameter int UW    = 12,
  parameter int TW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [UW-1:0] inner_o,
  output logic [TW-1:0] outer_o,
  output logic          inner_tc_o
);

  logic [UW-1:0] inner_q, inner_d;
  logic [TW-1:0] outer_q, outer_d;
  logic          outer_tc;

  assign inner_tc_o = (inner_q == UW'(INNER - 1));
  assign outer_tc   = (outer_q == TW'(OUTER));

  always_comb begin
    inner_d = inner_q;
    outer_d = outer_q;
    if (clr_i) begin
      inner_d = '0;
      outer_d = '0;
    end else if (en_i && !outer_tc) begin
      if (inner_tc_o) begin
        inner_d = '0;
        outer_d = outer_q + TW'(1);
      end else begin
        inner_d = inner_q + UW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner_q <= '0;
      outer_q <= '0;
    end else begin
      inner_q <= inner_d;
      outer_q <= outer_d;
    end
  end

  assign inner_o = inner_q;
  assign outer_o = outer_q;

endmodule

// File: rtl/memory_h_seq.sv
// Hidden-state memory sequencer: write pointer for h_t, read sweeps of one
// slot for h_{t-1}. Optional range checks under MEMORY_H_SEQ_BOUNDS_EN.
//
//   state    | meaning
//   RD_IDLE  | no sweep; rd_start accepted here only
//   RD_RUN   | loading slot addresses, one per cycle without a write
//   RD_DRAIN | last address loaded, waiting for it to be read
module memory_h_seq
  import lstm_mem_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_LSTM = 53,
  parameter int TIMESTEP = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seq_clr,
  input  logic             rd_start,
  input  logic [T_W-1:0]   rd_t,
  output logic             busy,
  output logic             seq_done,
  output logic             err,
  memory_h_seq_if.slave    bus
);

  logic [ADDR_W-1:0] wu, ru;
  logic [T_W-1:0]    wt;
  logic [0:0]        rd_sweep;
  logic              wu_tc, ru_tc;
  logic              h_full, h_ready, wr;
  logic [WIDTH-1:0]  h_word;

  logic [ADDR_W-1:0] wbase_q, wbase_d;
  logic              seq_done_q, seq_done_d;

  rd_state_e         state_q, state_d;
  logic              start_ok, load_en, consume, exhausted;
  logic              pend_q, pend_d, last_pend_q, last_pend_d;
  logic              rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [ADDR_W-1:0] base_q, base_d, rd_addr_q, rd_addr_d;

  // seq_clr blocks the handshake in its own cycle
  assign h_full  = (wt == T_W'(TIMESTEP));
  assign h_ready = !h_full && !seq_clr;
  assign wr      = bus.h_valid && h_ready;
  assign h_word  = bus.h_data;

  unit_step_counter #(
    .INNER(NUM_LSTM), .OUTER(TIMESTEP), .UW(ADDR_W), .TW(T_W)
  ) u_wr_cnt (
    .clk(clk), .rst_n(rst), .clr_i(seq_clr), .en_i(wr),
    .inner_o(wu), .outer_o(wt), .inner_tc_o(wu_tc)
  );

  unit_step_counter #(
    .INNER(NUM_LSTM), .OUTER(1), .UW(ADDR_W), .TW(1)
  ) u_rd_cnt (
    .clk(clk), .rst_n(rst), .clr_i(start_ok), .en_i(load_en),
    .inner_o(ru), .outer_o(rd_sweep), .inner_tc_o(ru_tc)
  );

  assign exhausted = rd_sweep[0];

`ifdef MEMORY_H_SEQ_BOUNDS_EN
  logic err_q, err_d;

  assign start_ok = rd_start && (state_q == RD_IDLE) && (rd_t <= T_W'(TIMESTEP));

  always_comb begin
    err_d = err_q;
    if (seq_clr)
      err_d = 1'b0;
    else if ((rd_start && (state_q == RD_IDLE) && (rd_t > T_W'(TIMESTEP))) ||
             (bus.h_valid && !h_ready))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`else
  assign start_ok = rd_start && (state_q == RD_IDLE);
  assign err      = 1'b0;
`endif

  // Slot base advances by one slot each time the unit counter wraps
  always_comb begin
    wbase_d = wbase_q;
    if (seq_clr)
      wbase_d = ADDR_W'(NUM_LSTM);
    else if (wr && wu_tc)
      wbase_d = wbase_q + ADDR_W'(NUM_LSTM);
  end

  assign seq_done_d = wr && wu_tc && (wt == T_W'(TIMESTEP - 1));

  // A write cycle freezes the read pipe: the memory cannot read then
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    consume = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (start_ok) state_d = RD_RUN;
      end
      RD_RUN: begin
        if (!wr) begin
          consume = pend_q;
          load_en = !exhausted;
          if (ru_tc) state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (!wr) begin
          consume = pend_q;
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    pend_d      = load_en ? 1'b1 : (consume ? 1'b0 : pend_q);
    rd_addr_d   = load_en ? (base_q + ru) : rd_addr_q;
    last_pend_d = load_en ? ru_tc : last_pend_q;
    rd_valid_d  = consume;
    rd_last_d   = consume && last_pend_q;
    base_d      = start_ok ? h_slot_addr(rd_t, {ADDR_W{1'b0}}, NUM_LSTM) : base_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RD_IDLE;
      wbase_q     <= ADDR_W'(NUM_LSTM);
      seq_done_q  <= 1'b0;
      pend_q      <= 1'b0;
      last_pend_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      base_q      <= '0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      wbase_q     <= wbase_d;
      seq_done_q  <= seq_done_d;
      pend_q      <= pend_d;
      last_pend_q <= last_pend_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      base_q      <= base_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign bus.h_ready  = h_ready;
  assign bus.wr       = wr;
  assign bus.wr_addr  = wr ? (wbase_q + wu) : '0;
  assign bus.wr_data  = h_word;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign busy         = (state_q != RD_IDLE);
  assign seq_done     = seq_done_q;

endmodule

// File: tb/tb_memory_h_seq.sv
// Scoreboard bench for memory_h_seq with NUM_LSTM=8, TIMESTEP=7 and a
// behavioural registered-read memory in front of the read port.
`timescale 1ns/1ps
module tb_memory_h_seq;

  localparam int NL = 8;
  localparam int TS = 7;
  localparam int W  = 32;

  typedef struct packed { logic [11:0] a; logic [31:0] d; } wexp_t;
  typedef struct packed { logic [31:0] d; logic l; } rexp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       seq_clr = 1'b0;
  logic       rd_start = 1'b0;
  logic [3:0] rd_t = 4'd0;
  logic       busy, seq_done, err;

  memory_h_seq_if #(.WIDTH(W)) bus();

  memory_h_seq #(.WIDTH(W), .NUM_LSTM(NL), .TIMESTEP(TS)) dut (
    .clk(clk), .rst(rst), .seq_clr(seq_clr), .rd_start(rd_start), .rd_t(rd_t),
    .busy(busy), .seq_done(seq_done), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten word a reads as 0x1000+a; no read on a write cycle
  logic [31:0] mem [0:127];
  logic        mem_init = 1'b0;
  logic [31:0] o_q;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h1000 + 32'(i);
      mem_init <= 1'b1;
    end else if (bus.wr) begin
      mem[bus.wr_addr[6:0]] <= bus.wr_data;
    end else begin
      o_q <= mem[bus.rd_addr[6:0]];
    end
  end

  int    n_pass = 0;
  int    n_total = 0;
  int    sd_cnt = 0;
  int    wp = 8;
  wexp_t wq[$];
  rexp_t rq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  task automatic push_rd(input int a0, input logic [31:0] dbase);
    rexp_t e;
    for (int k = 0; k < NL; k++) begin
      e.d = dbase | 32'(a0 + k);
      if (dbase == 32'h1000) e.d = 32'h1000 + 32'(a0 + k);
      e.l = (k == NL - 1);
      rq.push_back(e);
    end
  endtask

  task automatic drive_word();
    wexp_t e;
    bus.h_valid = 1'b1;
    bus.h_data  = 32'hD000 | 32'(wp);
    e.a = 12'(wp);
    e.d = 32'hD000 | 32'(wp);
    wq.push_back(e);
    wp++;
  endtask

  task automatic wr_word();
    drive_word();
    @(negedge clk);
    chk("h_ready_stream", {31'd0, bus.h_ready}, 32'd1);
    @(posedge clk); #1;
    bus.h_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    seq_clr = 1'b1;
    @(negedge clk);
    chk("h_ready_during_clr", {31'd0, bus.h_ready}, 32'd0);
    @(posedge clk); #1;
    seq_clr = 1'b0;
    wp = 8;
  endtask

  task automatic sweep(input logic [3:0] t, input int w1, input int w2,
                       output int first, output int span, output int vcnt, output int bcnt);
    int last;
    first = -1; last = -1; vcnt = 0; bcnt = 0;
    rd_t = t;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (i == w1 || i == w2) drive_word();
      @(negedge clk);
      if (bus.rd_valid) begin
        vcnt++;
        if (first < 0) first = i;
        last = i;
      end
      if (busy) bcnt++;
      @(posedge clk); #1;
      bus.h_valid = 1'b0;
    end
    span = (first < 0) ? 0 : last - first + 1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a read
  initial begin
    wexp_t we;
    rexp_t re;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.wr) begin
          if (wq.size() == 0) begin
            n_total++;
            $display("FAIL wr_unexpected actual addr=%h required=no write", bus.wr_addr);
          end else begin
            we = wq.pop_front();
            chk("wr_addr", {20'd0, bus.wr_addr}, {20'd0, we.a});
            chk("wr_data", bus.wr_data, we.d);
          end
        end
        if (bus.rd_valid) begin
          if (rq.size() == 0) begin
            n_total++;
            $display("FAIL rd_unexpected actual addr=%h required=no read", bus.rd_addr);
          end else begin
            re = rq.pop_front();
            chk("rd_data", o_q, re.d);
            chk("rd_last", {31'd0, bus.rd_last}, {31'd0, re.l});
          end
        end
        if (seq_done) sd_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int f, s, v, b, sd0;
    bus.h_valid = 1'b0;
    bus.h_data  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_rd_addr", {20'd0, bus.rd_addr}, 32'd0);
    chk("rst_seq_done", {31'd0, seq_done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_h_ready", {31'd0, bus.h_ready}, 32'd1);
    chk("rst_wr_addr", {20'd0, bus.wr_addr}, 32'd0);
    @(posedge clk); #1;

    // 1: eight words into slot 1
    for (int i = 0; i < NL; i++) wr_word();

    // 2: full sequence, seq_done, then clear
    clr_pulse();
    sd0 = sd_cnt;
    for (int i = 0; i < NL * TS; i++) wr_word();
    @(negedge clk);
    chk("seq_done_pulse", {31'd0, seq_done}, 32'd1);
    chk("h_ready_full", {31'd0, bus.h_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("seq_done_count", 32'(sd_cnt - sd0), 32'd1);
    @(posedge clk); #1;
    clr_pulse();
    wr_word();

    // 3: unstalled sweep of slot 3
    push_rd(24, 32'hD000);
    sweep(4'd3, 0, 0, f, s, v, b);
    chk("s3_first_valid", 32'(f), 32'd3);
    chk("s3_valid_cnt", 32'(v), 32'd8);
    chk("s3_span", 32'(s), 32'd8);
    chk("s3_busy_cnt", 32'(b), 32'd9);

    // 4: slot 0 sweep with two injected writes
    push_rd(0, 32'h1000);
    sweep(4'd0, 4, 6, f, s, v, b);
    chk("s0_valid_cnt", 32'(v), 32'd8);
    chk("s0_span", 32'(s), 32'd10);
    chk("s0_busy_cnt", 32'(b), 32'd11);

    // 5: seq_clr beats a simultaneous handshake
    seq_clr = 1'b1;
    bus.h_valid = 1'b1;
    bus.h_data = 32'hBAD0;
    @(negedge clk);
    chk("clr_wr", {31'd0, bus.wr}, 32'd0);
    chk("clr_h_ready", {31'd0, bus.h_ready}, 32'd0);
    @(posedge clk); #1;
    seq_clr = 1'b0;
    bus.h_valid = 1'b0;
    wp = 8;
    wr_word();
    chk("clr_err", {31'd0, err}, 32'd0);

    // 5b: reset mid-sweep aborts immediately
    push_rd(16, 32'hD000);
    rd_t = 4'd2;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("abort_rd_addr", {20'd0, bus.rd_addr}, 32'd0);
    rq.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    wp = 8;
    push_rd(8, 32'hD000);
    sweep(4'd1, 0, 0, f, s, v, b);
    chk("post_rst_valid_cnt", 32'(v), 32'd8);
    chk("post_rst_first_valid", 32'(f), 32'd3);

    // 6: out-of-range slot
`ifdef MEMORY_H_SEQ_BOUNDS_EN
    sweep(4'd9, 0, 0, f, s, v, b);
    chk("oor_valid_cnt", 32'(v), 32'd0);
    chk("oor_busy_cnt", 32'(b), 32'd0);
    chk("oor_err", {31'd0, err}, 32'd1);
    clr_pulse();
    chk("oor_err_cleared", {31'd0, err}, 32'd0);
`else
    push_rd(72, 32'h1000);
    sweep(4'd9, 0, 0, f, s, v, b);
    chk("oor_valid_cnt", 32'(v), 32'd8);
    chk("oor_busy_cnt", 32'(b), 32'd9);
    chk("oor_err", {31'd0, err}, 32'd0);
`endif

    repeat (4) @(posedge clk);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
